// File: rtl/fifo_reader.sv
// Paced drain engine for the cola_fifo read port: captures the head word, pops it, then dwells.
// Optional feature macro: FIFO_READER_COUNT_EN adds an 8-bit consumed-word counter output.
module fifo_reader #(
    parameter int W     = 3,
    parameter int N     = 26,
    parameter int DWELL = 50_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         empty,
    input  logic [W-1:0] data,
    output logic         rd,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         busy,
    output logic         underrun
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [7:0]   count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        HOLD
    } state_t;

    localparam logic [N-1:0] DWELL_LOAD = N'(DWELL - 1);

    state_t       state;
    logic [N-1:0] dwell_cnt;

    // The strobe is gated by empty so a foreign reader draining the FIFO can never cause an over-read.
    assign rd   = (state == POP) && !empty;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dout      <= '0;
            valid     <= 1'b0;
            underrun  <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !empty) begin
                        dout  <= data;
                        valid <= 1'b1;
                        state <= POP;
                    end
                end
                POP: begin
                    if (empty) begin
                        underrun <= 1'b1;
                    end
                    dwell_cnt <= DWELL_LOAD;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (dwell_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        dwell_cnt <= dwell_cnt - N'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_READER_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (rd) begin
            count <= count + 8'd1;
        end
    end
`endif

endmodule
